// File: rtl/seg_scan_capture_if.sv
// Scanned seven-segment display bus as seen from the display side.
// seg/pick are the raw time-multiplexed lines driven by the display driver;
// the remaining signals are the reconstructed digit values and status.
//   seg   : segment lines {a,b,c,d,e,f,g}, a = bit 6
//   pick  : digit selects {pick0,pick1,pick2,pick3}, pick0 = bit 3 = digit 0
//   d0..d3: last captured value per digit
//   vld   : per-digit captured-since-reset flags (pick bit order)
//   upd   : per-digit one-cycle write pulses (pick bit order)
//   err   : per-digit sticky undecodable-pattern flags (pick bit order)
//   frame : one-cycle pulse when all four digits have been refreshed
interface seg_scan_capture_if;
  logic [6:0] seg;
  logic [3:0] pick;
  logic [3:0] d0;
  logic [3:0] d1;
  logic [3:0] d2;
  logic [3:0] d3;
  logic [3:0] vld;
  logic [3:0] upd;
  logic [3:0] err;
  logic       frame;

  // Display driver side (or a bench standing in for it).
  modport master (
    output seg, pick,
    input  d0, d1, d2, d3, vld, upd, err, frame
  );

  // Capture block side.
  modport slave (
    input  seg, pick,
    output d0, d1, d2, d3, vld, upd, err, frame
  );
endinterface

// File: rtl/seg_scan_capture.sv
// Rebuilds the four hex digits shown on a time-multiplexed 4-digit
// seven-segment display bus.
//   clk : system clock, rising edge
//   r   : synchronous active-high reset
//   bus : seg_scan_capture_if.slave (seg/pick in, digits and status out)
// Parameters:
//   STABLE_CYCLES   : identical consecutive samples needed for a capture (1..15)
//   SEG_ACTIVE_LOW  : segment lines lit when low
//   PICK_ACTIVE_LOW : pick lines selected when low
// All per-digit masks (vld/upd/err) use the pick bit order: digit i is bit 3-i.
module seg_scan_capture #(
  parameter int unsigned STABLE_CYCLES   = 1,
  parameter bit          SEG_ACTIVE_LOW  = 1'b0,
  parameter bit          PICK_ACTIVE_LOW = 1'b0
) (
  input logic                clk,
  input logic                r,
  seg_scan_capture_if.slave  bus
);

  localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

  // {valid, value}: valid is 0 for any pattern outside the hex table.
  function automatic logic [4:0] seg_decode(input logic [6:0] p);
    logic [4:0] v;
    v = 5'b0_0000;
    case (p)
      7'h7E:   v = {1'b1, 4'h0};
      7'h30:   v = {1'b1, 4'h1};
      7'h6D:   v = {1'b1, 4'h2};
      7'h79:   v = {1'b1, 4'h3};
      7'h33:   v = {1'b1, 4'h4};
      7'h5B:   v = {1'b1, 4'h5};
      7'h5F:   v = {1'b1, 4'h6};
      7'h70:   v = {1'b1, 4'h7};
      7'h7F:   v = {1'b1, 4'h8};
      7'h7B:   v = {1'b1, 4'h9};
      7'h77:   v = {1'b1, 4'hA};
      7'h1F:   v = {1'b1, 4'hB};
      7'h4E:   v = {1'b1, 4'hC};
      7'h3D:   v = {1'b1, 4'hD};
      7'h4F:   v = {1'b1, 4'hE};
      7'h47:   v = {1'b1, 4'hF};
      default: v = 5'b0_0000;
    endcase
    return v;
  endfunction

  logic [6:0]  seg_s;
  logic [3:0]  pick_s;
  logic [10:0] sample_r;     // {pick, seg} after polarity normalisation
  logic [3:0]  cnt_r;
  logic [3:0]  cnt_next_s;
  logic        cap_r;        // sample_r holds a pattern that just became stable
  logic        cap_next_s;
  logic        onehot_s;
  logic        same_s;

  logic [4:0]  dec_s;
  logic [3:0]  sel_s;
  logic [3:0]  upd_next_s;
  logic [3:0]  err_set_s;
  logic        frame_next_s;

  logic [3:0]  digit_r [4];
  logic [3:0]  vld_r;
  logic [3:0]  upd_r;
  logic [3:0]  err_r;
  logic [3:0]  seen_r;
  logic        frame_r;

  // Normalise polarity so that 1 always means lit / selected.
  always_comb begin
    seg_s  = SEG_ACTIVE_LOW  ? ~bus.seg  : bus.seg;
    pick_s = PICK_ACTIVE_LOW ? ~bus.pick : bus.pick;
  end

  // Stability counter: cnt is computed against the previous sample so that a
  // new pattern reads cnt = 1 on the same edge it enters the sample register.
  // The capture flag fires only on the step that reaches STABLE, so a held
  // pattern sitting at the saturated value never re-captures.
  always_comb begin
    onehot_s   = (pick_s != 4'd0) && ((pick_s & (pick_s - 4'd1)) == 4'd0);
    same_s     = ({pick_s, seg_s} == sample_r);
    cnt_next_s = cnt_r;
    cap_next_s = 1'b0;
    if (!onehot_s) begin
      cnt_next_s = 4'd0;
    end else if (same_s) begin
      if (cnt_r < STABLE) begin
        cnt_next_s = cnt_r + 4'd1;
        cap_next_s = ((cnt_r + 4'd1) == STABLE);
      end else begin
        cnt_next_s = STABLE;
      end
    end else begin
      cnt_next_s = 4'd1;
      cap_next_s = (STABLE == 4'd1);
    end
  end

  // Sample register, counter and capture flag.
  always_ff @(posedge clk) begin
    if (r) begin
      sample_r <= 11'd0;
      cnt_r    <= 4'd0;
      cap_r    <= 1'b0;
    end else begin
      sample_r <= {pick_s, seg_s};
      cnt_r    <= cnt_next_s;
      cap_r    <= cap_next_s;
    end
  end

  // Decode the captured sample and work out which digit it addresses.
  // seen clears on a frame, so the completing digit starts no new frame.
  always_comb begin
    dec_s        = seg_decode(sample_r[6:0]);
    sel_s        = sample_r[10:7];
    upd_next_s   = 4'd0;
    err_set_s    = 4'd0;
    if (cap_r) begin
      if (dec_s[4]) begin
        upd_next_s = sel_s;
      end else begin
        err_set_s  = sel_s;
      end
    end else begin
      upd_next_s = 4'd0;
      err_set_s  = 4'd0;
    end
    frame_next_s = (upd_next_s != 4'd0) && ((seen_r | upd_next_s) == 4'b1111);
  end

  // Output registers: digit values, status masks and frame tracking.
  always_ff @(posedge clk) begin
    if (r) begin
      for (int i = 0; i < 4; i++) begin
        digit_r[i] <= 4'd0;
      end
      vld_r   <= 4'd0;
      upd_r   <= 4'd0;
      err_r   <= 4'd0;
      seen_r  <= 4'd0;
      frame_r <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (upd_next_s[3-i]) begin
          digit_r[i] <= dec_s[3:0];
        end
      end
      vld_r   <= vld_r | upd_next_s;
      upd_r   <= upd_next_s;
      err_r   <= err_r | err_set_s;
      seen_r  <= frame_next_s ? 4'd0 : (seen_r | upd_next_s);
      frame_r <= frame_next_s;
    end
  end

  assign bus.d0    = digit_r[0];
  assign bus.d1    = digit_r[1];
  assign bus.d2    = digit_r[2];
  assign bus.d3    = digit_r[3];
  assign bus.vld   = vld_r;
  assign bus.upd   = upd_r;
  assign bus.err   = err_r;
  assign bus.frame = frame_r;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture: three instances cover the default
// configuration, STABLE_CYCLES = 3, and fully active-low lines.
module tb_seg_scan_capture;

  logic clk;
  logic r;
  int   checks;
  int   errors;

  seg_scan_capture_if ia ();
  seg_scan_capture_if ib ();
  seg_scan_capture_if ic ();

  seg_scan_capture #(.STABLE_CYCLES(1), .SEG_ACTIVE_LOW(1'b0), .PICK_ACTIVE_LOW(1'b0))
    u_def (.clk(clk), .r(r), .bus(ia));
  seg_scan_capture #(.STABLE_CYCLES(3), .SEG_ACTIVE_LOW(1'b0), .PICK_ACTIVE_LOW(1'b0))
    u_s3  (.clk(clk), .r(r), .bus(ib));
  seg_scan_capture #(.STABLE_CYCLES(1), .SEG_ACTIVE_LOW(1'b1), .PICK_ACTIVE_LOW(1'b1))
    u_pol (.clk(clk), .r(r), .bus(ic));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    r = 1'b1;
    tick();
    tick();
    r = 1'b0;
  endtask

  logic [3:0] vec_pick [4];
  logic [6:0] vec_seg  [4];
  logic [3:0] upd_seen;

  initial begin
    checks = 0;
    errors = 0;
    vec_pick[0] = 4'b1000; vec_seg[0] = 7'h30;
    vec_pick[1] = 4'b0100; vec_seg[1] = 7'h6D;
    vec_pick[2] = 4'b0010; vec_seg[2] = 7'h79;
    vec_pick[3] = 4'b0001; vec_seg[3] = 7'h33;

    r = 1'b1;
    ia.pick = 4'b1010; ia.seg = 7'h55;
    ib.pick = 4'b0000; ib.seg = 7'h00;
    ic.pick = 4'b1111; ic.seg = 7'h7F;
    #1;

    // Reset to idle with arbitrary inputs on the default instance.
    tick();
    ia.pick = 4'b0100; ia.seg = 7'h30;
    tick();
    check_val("rst_d0",    32'(ia.d0), 32'h0);
    check_val("rst_d3",    32'(ia.d3), 32'h0);
    check_val("rst_vld",   32'(ia.vld), 32'h0);
    check_val("rst_err",   32'(ia.err), 32'h0);
    check_val("rst_upd",   32'(ia.upd), 32'h0);
    check_val("rst_frame", 32'(ia.frame), 32'h0);
    r = 1'b0;

    // Default scan, one digit per cycle; outputs lag inputs by two edges.
    for (int n = 0; n < 12; n++) begin
      ia.pick = vec_pick[n % 4];
      ia.seg  = vec_seg[n % 4];
      tick();
      if (n == 0) begin
        check_val("scan_upd_first", 32'(ia.upd), 32'h0);
      end else begin
        check_val("scan_upd",   32'(ia.upd), 32'(vec_pick[(n - 1) % 4]));
        check_val("scan_frame", 32'(ia.frame), 32'(((n - 1) % 4) == 3));
      end
    end
    check_val("scan_d0",  32'(ia.d0), 32'h1);
    check_val("scan_d1",  32'(ia.d1), 32'h2);
    check_val("scan_d2",  32'(ia.d2), 32'h3);
    check_val("scan_d3",  32'(ia.d3), 32'h4);
    check_val("scan_vld", 32'(ia.vld), 32'hF);
    check_val("scan_err", 32'(ia.err), 32'h0);

    // Reset mid-run clears all outputs on the next edge.
    r = 1'b1;
    tick();
    check_val("mid_rst_d0",    32'(ia.d0), 32'h0);
    check_val("mid_rst_d2",    32'(ia.d2), 32'h0);
    check_val("mid_rst_vld",   32'(ia.vld), 32'h0);
    check_val("mid_rst_upd",   32'(ia.upd), 32'h0);
    check_val("mid_rst_frame", 32'(ia.frame), 32'h0);
    r = 1'b0;
    // Held pattern 0001/33 starts a fresh run after reset.
    tick();
    check_val("post_rst_upd0", 32'(ia.upd), 32'h0);
    tick();
    check_val("post_rst_upd1", 32'(ia.upd), 32'h1);
    check_val("post_rst_d3",   32'(ia.d3), 32'h4);

    // Bad selects never capture.
    do_reset();
    upd_seen = 4'd0;
    ia.pick = 4'b0000; ia.seg = 7'h7E;
    for (int n = 0; n < 5; n++) begin
      tick();
      upd_seen = upd_seen | ia.upd;
    end
    ia.pick = 4'b1100; ia.seg = 7'h7E;
    for (int n = 0; n < 5; n++) begin
      tick();
      upd_seen = upd_seen | ia.upd | ia.err;
    end
    check_val("badsel_no_upd", 32'(upd_seen), 32'h0);
    check_val("badsel_vld",    32'(ia.vld), 32'h0);
    ia.pick = 4'b0001; ia.seg = 7'h47;
    tick();
    check_val("badsel_then_upd0", 32'(ia.upd), 32'h0);
    tick();
    check_val("badsel_then_upd1", 32'(ia.upd), 32'h1);
    check_val("badsel_then_d3",   32'(ia.d3), 32'hF);

    // Blank pattern on digit 2 flags an error only.
    ia.pick = 4'b0010; ia.seg = 7'h00;
    upd_seen = 4'd0;
    for (int n = 0; n < 3; n++) begin
      tick();
      upd_seen = upd_seen | ia.upd;
    end
    check_val("inv_err", 32'(ia.err), 32'h2);
    check_val("inv_vld", 32'(ia.vld), 32'h1);
    check_val("inv_upd", 32'(upd_seen), 32'h0);
    check_val("inv_d2",  32'(ia.d2), 32'h0);
    ia.seg = 7'h4F;
    tick();
    tick();
    check_val("inv_fix_upd", 32'(ia.upd), 32'h2);
    check_val("inv_fix_d2",  32'(ia.d2), 32'hE);
    check_val("inv_fix_err", 32'(ia.err), 32'h2);
    tick();
    check_val("inv_hold_upd", 32'(ia.upd), 32'h0);
    ia.pick = 4'b0000; ia.seg = 7'h00;

    // Stability filter with STABLE_CYCLES = 3: the 7F glitch is rejected.
    do_reset();
    ib.pick = 4'b0100;
    for (int t = 1; t <= 8; t++) begin
      ib.seg = (t <= 2) ? 7'h7F : 7'h77;
      tick();
      check_val("stab_upd", 32'(ib.upd), (t == 6) ? 32'h4 : 32'h0);
      check_val("stab_err", 32'(ib.err), 32'h0);
    end
    check_val("stab_d1",  32'(ib.d1), 32'hA);
    check_val("stab_vld", 32'(ib.vld), 32'h4);
    ib.pick = 4'b0000;

    // Active-low lines: pick 0111 selects digit 0, seg 24 is a lit 5B.
    do_reset();
    ic.pick = 4'b0111; ic.seg = 7'h24;
    tick();
    check_val("pol_upd0", 32'(ic.upd), 32'h0);
    tick();
    check_val("pol_upd1", 32'(ic.upd), 32'h8);
    check_val("pol_d0",   32'(ic.d0), 32'h5);
    check_val("pol_err",  32'(ic.err), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
